inv_key_scheduler: RTL and testbench



---
 rtl/aes_pkg.sv | 10 +
 rtl/g_function.sv | 29 ++
 rtl/inv_key_scheduler.sv | 81 ++++++++
 tb/tb_inv_key_scheduler.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 key-schedule constants and the inverse scheduler state type
package aes_pkg;
  localparam int NUM_ROUNDS = 10;
  localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  typedef enum logic [1:0] {IDLE, EXPAND, EMIT} inv_ks_state_t;
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    return (r >= 4'd1 && r <= 4'd10) ? RCON[r] : 8'h00;
  endfunction
endpackage

// File: rtl/g_function.sv
// g_function: AES key-expansion g(): SubWord(RotWord(x)) xor {rcon, 24'h0}
module g_function (
  input  logic [31:0] input_word,
  input  logic [7:0]  current_round_constant,
  output logic [31:0] gee
);
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  logic [31:0] rot;
  assign rot = {input_word[23:0], input_word[31:24]};
  assign gee = {SBOX[rot[31:24]] ^ current_round_constant, SBOX[rot[23:16]],
                SBOX[rot[15:8]], SBOX[rot[7:0]]};
endmodule

// File: rtl/inv_key_scheduler.sv
// inv_key_scheduler: emits AES-128 round keys 10..0, regenerating each with the inverse key expansion
module inv_key_scheduler
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic         key_is_final,
  input  logic [127:0] key_in,
  input  logic         abort,
  input  logic         key_ready,
  output logic         key_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_index,
  output logic         busy,
  output logic         done
);
  inv_ks_state_t state, state_next;
  logic [127:0] w, w_next, fwd, inv;
  logic [3:0] round, round_next;
  logic done_next;
  logic [31:0] w0, w1, w2, w3, p3, g_in, gee, n0, n1, n2;
  logic [7:0] rc;
  assign {w0, w1, w2, w3} = w;
  assign p3 = w3 ^ w2;
  assign g_in = (state == EXPAND) ? w3 : p3;
  assign rc = rcon_of((state == EXPAND) ? round + 4'd1 : round);
  g_function u_g (.input_word(g_in), .current_round_constant(rc), .gee(gee));
  assign n0 = w0 ^ gee;
  assign n1 = n0 ^ w1;
  assign n2 = n1 ^ w2;
  assign fwd = {n0, n1, n2, n2 ^ w3};
  assign inv = {w0 ^ gee, w1 ^ w0, w2 ^ w1, p3};
  assign round_key = w;
  assign round_index = round;
  assign key_valid = (state == EMIT);
  assign busy = (state != IDLE);
  // next-state logic: load, forward expansion to round 10, then inverse steps on each accept
  always_comb begin
    state_next = state;
    w_next = w;
    round_next = round;
    done_next = 1'b0;
    if (abort)
      state_next = IDLE;
    else
      case (state)
        IDLE: if (start) begin
          w_next = key_in;
          round_next = key_is_final ? 4'(NUM_ROUNDS) : 4'd0;
          state_next = key_is_final ? EMIT : EXPAND;
        end
        EXPAND: begin
          w_next = fwd;
          round_next = round + 4'd1;
          state_next = (round == 4'(NUM_ROUNDS - 1)) ? EMIT : EXPAND;
        end
        EMIT: if (key_ready) begin
          w_next = (round != 4'd0) ? inv : w;
          round_next = (round != 4'd0) ? round - 4'd1 : round;
          state_next = (round != 4'd0) ? EMIT : IDLE;
          done_next = (round == 4'd0);
        end
        default: state_next = IDLE;
      endcase
  end
  // state, key words and round counter with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
      w <= '0;
      round <= '0;
      done <= 1'b0;
    end else begin
      state <= state_next;
      w <= w_next;
      round <= round_next;
      done <= done_next;
    end
  end
endmodule

// File: tb/tb_inv_key_scheduler.sv
// tb_inv_key_scheduler: directed self-checking bench against FIPS-197 AES-128 round keys
module tb_inv_key_scheduler;
  logic clk = 1'b0, n_rst = 1'b0, start = 1'b0, key_is_final = 1'b0, abort = 1'b0, key_ready = 1'b0;
  logic [127:0] key_in = '0;
  logic key_valid, busy, done;
  logic [127:0] round_key;
  logic [3:0] round_index;
  logic [127:0] rk [11];
  int total = 0, bad = 0;

  inv_key_scheduler dut (.clk(clk), .n_rst(n_rst), .start(start), .key_is_final(key_is_final),
    .key_in(key_in), .abort(abort), .key_ready(key_ready), .key_valid(key_valid),
    .round_key(round_key), .round_index(round_index), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_key(input logic fin, input logic [127:0] k, input int lat);
    int n;
    start = 1'b1; key_is_final = fin; key_in = k;
    tick;
    start = 1'b0; n = 1;
    while (!key_valid && n < 20) begin tick; n++; end
    total++;
    if (n !== lat) begin bad++; $display("FAIL latency got=%0d exp=%0d", n, lat); end
  endtask

  task automatic drain(input int from, input int max_stall);
    int s;
    for (int i = from; i >= 0; i--) begin
      s = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
      key_ready = (s == 0);
      repeat (s) begin
        tick;
        total++;
        if (key_valid !== 1'b1 || round_index !== 4'(i) || round_key !== rk[i]) begin
          bad++; $display("FAIL stall_hold idx=%0d got v=%b i=%0d k=%h", i, key_valid, round_index, round_key);
        end
      end
      total++;
      if (key_valid !== 1'b1 || round_index !== 4'(i)) begin
        bad++; $display("FAIL emit_idx got v=%b i=%0d exp i=%0d", key_valid, round_index, i);
      end
      total++;
      if (round_key !== rk[i]) begin bad++; $display("FAIL emit_key idx=%0d got=%h exp=%h", i, round_key, rk[i]); end
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL early_done idx=%0d got=%b exp=0", i, done); end
      key_ready = 1'b1;
      tick;
    end
    key_ready = 1'b0;
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || key_valid !== 1'b0) begin
      bad++; $display("FAIL end_done got d=%b b=%b v=%b exp 1 0 0", done, busy, key_valid);
    end
    tick;
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    tick; tick;
    total++;
    if (round_key !== '0 || round_index !== 4'd0 || key_valid || busy || done) begin
      bad++; $display("FAIL reset got k=%h i=%0d v=%b b=%b d=%b exp all 0", round_key, round_index, key_valid, busy, done);
    end
    n_rst = 1'b1;
    tick;
  endtask

  task automatic test_cipher_key;
    key_ready = 1'b1;
    start_key(1'b0, rk[0], 11);
    drain(10, 0);
  endtask

  task automatic test_final_key;
    start_key(1'b1, rk[10], 1);
    drain(10, 0);
  endtask

  task automatic test_stall;
    start_key(1'b1, rk[10], 1);
    drain(10, 5);
    start_key(1'b0, rk[0], 11);
    drain(10, 5);
  endtask

  task automatic test_abort_emit;
    start_key(1'b1, rk[10], 1);
    key_ready = 1'b1;
    repeat (4) tick;
    total++;
    if (round_index !== 4'd6 || round_key !== rk[6]) begin
      bad++; $display("FAIL pre_abort got i=%0d k=%h exp i=6", round_index, round_key);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0; key_ready = 1'b0;
    total++;
    if (key_valid || busy || done) begin bad++; $display("FAIL abort_emit got v=%b b=%b d=%b exp 0", key_valid, busy, done); end
    tick;
    total++;
    if (done || busy) begin bad++; $display("FAIL abort_emit_idle got d=%b b=%b exp 0", done, busy); end
    start_key(1'b1, rk[10], 1);
    drain(10, 0);
  endtask

  task automatic test_abort_expand;
    start = 1'b1; key_is_final = 1'b0; key_in = rk[0];
    tick;
    start = 1'b0;
    repeat (3) tick;
    total++;
    if (busy !== 1'b1 || key_valid !== 1'b0) begin bad++; $display("FAIL expand_busy got b=%b v=%b exp 1 0", busy, key_valid); end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    total++;
    if (key_valid || busy || done) begin bad++; $display("FAIL abort_expand got v=%b b=%b d=%b exp 0", key_valid, busy, done); end
    repeat (12) begin
      tick;
      total++;
      if (key_valid || done) begin bad++; $display("FAIL abort_stays got v=%b d=%b exp 0", key_valid, done); end
    end
    abort = 1'b1; start = 1'b1; key_is_final = 1'b1; key_in = rk[10];
    tick;
    abort = 1'b0; start = 1'b0;
    total++;
    if (busy || key_valid) begin bad++; $display("FAIL abort_start got b=%b v=%b exp 0", busy, key_valid); end
    key_ready = 1'b1;
    start_key(1'b0, rk[0], 11);
    drain(10, 0);
  endtask

  task automatic test_start_ignored;
    int n;
    key_ready = 1'b1;
    start = 1'b1; key_is_final = 1'b0; key_in = rk[0];
    tick;
    start = 1'b0;
    tick; tick;
    start = 1'b1; key_is_final = 1'b1; key_in = 128'hdeadbeef_00000000_12345678_9abcdef0;
    tick;
    start = 1'b0; n = 4;
    while (!key_valid && n < 20) begin tick; n++; end
    total++;
    if (n !== 11) begin bad++; $display("FAIL ignore_expand_lat got=%0d exp=11", n); end
    key_ready = 1'b0; start = 1'b1; key_in = rk[3];
    tick;
    start = 1'b0;
    total++;
    if (round_index !== 4'd10 || round_key !== rk[10]) begin
      bad++; $display("FAIL ignore_emit got i=%0d k=%h exp i=10", round_index, round_key);
    end
    drain(10, 0);
  endtask

  task automatic test_reset_mid;
    start_key(1'b1, rk[10], 1);
    key_ready = 1'b1;
    repeat (3) tick;
    key_ready = 1'b0;
    n_rst = 1'b0;
    #3;
    total++;
    if (key_valid !== 1'b1 || round_index !== 4'd7 || round_key !== rk[7] || busy !== 1'b1) begin
      bad++; $display("FAIL rst_sync got v=%b i=%0d k=%h exp v=1 i=7", key_valid, round_index, round_key);
    end
    tick;
    total++;
    if (round_key !== '0 || round_index !== 4'd0 || key_valid || busy || done) begin
      bad++; $display("FAIL rst_mid got k=%h i=%0d v=%b b=%b d=%b exp all 0", round_key, round_index, key_valid, busy, done);
    end
    n_rst = 1'b1;
    tick;
    start_key(1'b0, rk[0], 11);
    drain(10, 2);
  endtask

  initial begin
    rk[0]  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    rk[1]  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    rk[2]  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
    rk[3]  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
    rk[4]  = 128'hef44a541_a8525b7f_b671253b_db0bad00;
    rk[5]  = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
    rk[6]  = 128'h6d88a37a_110b3efd_dbf98641_ca0093fd;
    rk[7]  = 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f;
    rk[8]  = 128'head27321_b58dbad2_312bf560_7f8d292f;
    rk[9]  = 128'hac7766f3_19fadc21_28d12941_575c006e;
    rk[10] = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    test_reset;
    test_cipher_key;
    test_final_key;
    test_stall;
    test_abort_emit;
    test_abort_expand;
    test_start_ignored;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
